// File: rtl/video_timing_pkg.sv
// video_timing_pkg: shared widths and default geometry for the video timing path.
package video_timing_pkg;
  localparam int HCNT_W = 9;
  localparam int VCNT_W = 9;
  localparam int DIV_W = 4;
  localparam int H_TOTAL_DEF = 454;
  localparam int V_TOTAL_DEF = 262;
  localparam int CE_DIV_DEF = 4;
endpackage

// File: rtl/mod_counter.sv
// mod_counter: enabled modulo-MODULUS up-counter with terminal-count flag and async clear.
module mod_counter #(
  parameter int WIDTH = 9,
  parameter int MODULUS = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  output logic [WIDTH-1:0] count,
  output logic             tc
);
  assign tc = count == WIDTH'(MODULUS - 1);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) count <= '0;
    else if (en) count <= tc ? '0 : count + WIDTH'(1);
endmodule

// File: rtl/hv_timing_ctrl.sv
// hv_timing_ctrl: pixel-enable divider, H/V counters, bit taps and line/frame reset pulses.
// Optional macro HV_FREEZE_EN adds a FREEZE input that stalls all counting.
module hv_timing_ctrl
  import video_timing_pkg::*;
#(
  parameter int CE_DIV = CE_DIV_DEF,
  parameter int H_TOTAL = H_TOTAL_DEF,
  parameter int V_TOTAL = V_TOTAL_DEF
) (
  input  logic              CLK_DRV,
  input  logic              RESET_N,
`ifdef HV_FREEZE_EN
  input  logic              FREEZE,
`endif
  output logic              PIX_CE,
  output logic [HCNT_W-1:0] HCNT,
  output logic [VCNT_W-1:0] VCNT,
  output logic              _16H,
  output logic              _32H,
  output logic              _64H,
  output logic              _4V,
  output logic              _8V,
  output logic              _16V,
  output logic              HRESET_N,
  output logic              VRESET,
  output logic              FRAME_START
);
  localparam logic [HCNT_W-1:0] H_PRE = HCNT_W'(H_TOTAL - 2);
  logic run, div_tc, h_tc, v_tc, pix_ce_q, fs_q, hrst_n_q, vrst_q;
`ifdef HV_FREEZE_EN
  assign run = !FREEZE;
`else
  assign run = 1'b1;
`endif
  // Masking (rather than clearing) pix_ce_q lets a pending pixel survive a freeze.
  assign PIX_CE = pix_ce_q & run;
  assign FRAME_START = fs_q & run;
  assign HRESET_N = hrst_n_q;
  assign VRESET = vrst_q;
  assign {_64H, _32H, _16H} = HCNT[6:4];
  assign {_16V, _8V, _4V} = VCNT[4:2];
  mod_counter #(.WIDTH(DIV_W), .MODULUS(CE_DIV)) u_div (
    .clk(CLK_DRV), .rst_n(RESET_N), .en(run), .count(), .tc(div_tc)
  );
  mod_counter #(.WIDTH(HCNT_W), .MODULUS(H_TOTAL)) u_h (
    .clk(CLK_DRV), .rst_n(RESET_N), .en(PIX_CE), .count(HCNT), .tc(h_tc)
  );
  mod_counter #(.WIDTH(VCNT_W), .MODULUS(V_TOTAL)) u_v (
    .clk(CLK_DRV), .rst_n(RESET_N), .en(PIX_CE & h_tc), .count(VCNT), .tc(v_tc)
  );
  // Pulses decode the count HCNT is about to take, so they move on the same edge as HCNT.
  always_ff @(posedge CLK_DRV or negedge RESET_N)
    if (!RESET_N) begin
      pix_ce_q <= 1'b0;
      fs_q <= 1'b0;
      hrst_n_q <= 1'b1;
      vrst_q <= 1'b0;
    end else begin
      if (run) pix_ce_q <= div_tc;
      fs_q <= PIX_CE & h_tc & v_tc;
      if (PIX_CE) begin
        hrst_n_q <= HCNT != H_PRE;
        vrst_q <= (HCNT == H_PRE) & v_tc;
      end
    end
endmodule

// File: tb/tb_hv_timing_ctrl.sv
// tb_hv_timing_ctrl: directed vector table plus reset-restart and freeze sequences.
module tb_hv_timing_ctrl;
  logic CLK_DRV = 1'b0, RESET_N = 1'b0, FREEZE = 1'b0;
  logic PIX_CE, _16H, _32H, _64H, _4V, _8V, _16V, HRESET_N, VRESET, FRAME_START;
  logic [8:0] HCNT, VCNT;
  int cyc, total = 0, bad = 0;

  hv_timing_ctrl #(.CE_DIV(4), .H_TOTAL(454), .V_TOTAL(14)) dut (
    .CLK_DRV(CLK_DRV), .RESET_N(RESET_N),
`ifdef HV_FREEZE_EN
    .FREEZE(FREEZE),
`endif
    .PIX_CE(PIX_CE), .HCNT(HCNT), .VCNT(VCNT),
    ._16H(_16H), ._32H(_32H), ._64H(_64H), ._4V(_4V), ._8V(_8V), ._16V(_16V),
    .HRESET_N(HRESET_N), .VRESET(VRESET), .FRAME_START(FRAME_START)
  );

  always #5 CLK_DRV = ~CLK_DRV;
  always @(posedge CLK_DRV or negedge RESET_N)
    if (!RESET_N) cyc <= 0;
    else cyc <= cyc + 1;

  typedef struct {
    int n;
    logic pce;
    int h;
    int v;
    logic hrn;
    logic vr;
    logic fs;
  } vec_t;
  vec_t vt[$];

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  task automatic chk_vec(input vec_t e);
    logic [8:0] hb, vb;
    hb = e.h[8:0];
    vb = e.v[8:0];
    chk($sformatf("n=%0d pix_ce", e.n), int'(PIX_CE), int'(e.pce));
    chk($sformatf("n=%0d hcnt", e.n), int'(HCNT), e.h);
    chk($sformatf("n=%0d vcnt", e.n), int'(VCNT), e.v);
    chk($sformatf("n=%0d hreset_n", e.n), int'(HRESET_N), int'(e.hrn));
    chk($sformatf("n=%0d vreset", e.n), int'(VRESET), int'(e.vr));
    chk($sformatf("n=%0d frame_start", e.n), int'(FRAME_START), int'(e.fs));
    chk($sformatf("n=%0d taps", e.n), int'({_16H, _32H, _64H, _4V, _8V, _16V}),
        int'({hb[4], hb[5], hb[6], vb[2], vb[3], vb[4]}));
  endtask

  initial begin
    int k;
    //            n      pce h    v   hrn vr fs
    vt.push_back('{0,     0, 0,   0,  1,  0, 0});
    vt.push_back('{3,     0, 0,   0,  1,  0, 0});
    vt.push_back('{4,     1, 0,   0,  1,  0, 0});
    vt.push_back('{5,     0, 1,   0,  1,  0, 0});
    vt.push_back('{8,     1, 1,   0,  1,  0, 0});
    vt.push_back('{9,     0, 2,   0,  1,  0, 0});
    vt.push_back('{321,   0, 80,  0,  1,  0, 0});
    vt.push_back('{1812,  1, 452, 0,  1,  0, 0});
    vt.push_back('{1813,  0, 453, 0,  0,  0, 0});
    vt.push_back('{1816,  1, 453, 0,  0,  0, 0});
    vt.push_back('{1817,  0, 0,   1,  1,  0, 0});
    vt.push_back('{3628,  1, 452, 1,  1,  0, 0});
    vt.push_back('{3629,  0, 453, 1,  0,  0, 0});
    vt.push_back('{21793, 0, 0,   12, 1,  0, 0});
    vt.push_back('{25420, 1, 452, 13, 1,  0, 0});
    vt.push_back('{25421, 0, 453, 13, 0,  1, 0});
    vt.push_back('{25424, 1, 453, 13, 0,  1, 0});
    vt.push_back('{25425, 0, 0,   0,  1,  0, 1});
    vt.push_back('{25426, 0, 0,   0,  1,  0, 0});
    repeat (3) @(negedge CLK_DRV);
    RESET_N = 1'b1;
    #1;
    foreach (vt[i]) begin
      while (cyc < vt[i].n) @(negedge CLK_DRV);
      chk_vec(vt[i]);
    end

    k = 0;
    while (!(HCNT == 9'd200 && VCNT == 9'd2) && k < 40000) begin
      @(negedge CLK_DRV);
      k++;
    end
    chk("reach h200 v2", int'(HCNT == 9'd200 && VCNT == 9'd2), 1);
    #2 RESET_N = 1'b0;
    #1;
    chk("async rst pix_ce", int'(PIX_CE), 0);
    chk("async rst hcnt", int'(HCNT), 0);
    chk("async rst vcnt", int'(VCNT), 0);
    chk("async rst hreset_n", int'(HRESET_N), 1);
    chk("async rst vreset", int'(VRESET), 0);
    chk("async rst frame_start", int'(FRAME_START), 0);
    @(negedge CLK_DRV);
    RESET_N = 1'b1;
    #1;
    k = 0;
    while (!FRAME_START && k < 30000) begin
      @(negedge CLK_DRV);
      k++;
    end
    chk("restart first frame_start cycle", cyc, 25425);

`ifdef HV_FREEZE_EN
    begin
      int pulses, frz, held, n;
      logic seen_low;
      k = 0;
      while (HRESET_N && k < 4000) begin @(negedge CLK_DRV); k++; end
      while (!HRESET_N && k < 4000) begin @(negedge CLK_DRV); k++; end
      chk("freeze line start hcnt", int'(HCNT), 0);
      pulses = 0;
      frz = -1;
      held = 0;
      seen_low = 1'b0;
      n = 0;
      while (n < 4000) begin
        @(negedge CLK_DRV);
        n++;
        if (frz < 0 && pulses == 100) begin
          FREEZE = 1'b1;
          frz = 37;
          held = int'(HCNT);
        end else if (frz > 0) begin
          frz--;
          if (frz == 0) FREEZE = 1'b0;
        end
        #1;
        if (FREEZE) begin
          chk("frozen pix_ce", int'(PIX_CE), 0);
          chk("frozen hcnt", int'(HCNT), held);
        end
        if (PIX_CE) pulses++;
        if (!HRESET_N) seen_low = 1'b1;
        else if (seen_low) break;
      end
      chk("freeze held hcnt", held, 100);
      chk("freeze line pixel count", pulses, 454);
      chk("freeze line end hcnt", int'(HCNT), 0);
    end
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
